// File: rtl/hist_pkg.sv
// Shared constants for the histogram accumulation front end: FSM state codes,
// drain depth and bin-count derivation.
package hist_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Matches the S -> R -> A -> write pipeline depth behind the last selected pixel.
    localparam int DRAIN_CYCLES = 3;

    function automatic int nbins(input int pixel_w);
        return 1 << pixel_w;
    endfunction

endpackage

// File: rtl/hist_fwd_acc.sv
// A stage of the histogram pipeline: two-entry write forwarding and increment.
// Build option HIST_SAT_EN: saturate counts at all-ones instead of wrapping.
module hist_fwd_acc
    import hist_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int BIN_W  = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [BIN_W-1:0]  rdata,
    input  logic              wr0_we,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [BIN_W-1:0]  wr0_data,
    input  logic              wr1_we,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [BIN_W-1:0]  wr1_data,
    output logic [BIN_W-1:0]  cnt
);

    logic [BIN_W-1:0] src;

    // NOTE: defaults assigned first so every path drives src and cnt; no latch is inferred.
    always_comb begin
        src = rdata;
        // The write in flight this cycle is newer than the one from last cycle.
        if (wr0_we && (wr0_addr == addr)) begin
            src = wr0_data;
        end else if (wr1_we && (wr1_addr == addr)) begin
            src = wr1_data;
        end
`ifdef HIST_SAT_EN
        cnt = (&src) ? src : src + BIN_W'(1);
`else
        cnt = src + BIN_W'(1);
`endif
    end

endmodule

// File: rtl/hist_accum_pipe.sv
// Histogram accumulation front end: clears a bin bank, streams packed pixels
// through S/R/A stages into bin memory, then signals done. Option: HIST_SAT_EN.
module hist_accum_pipe
    import hist_pkg::*;
#(
    parameter int PIXEL_W         = 8,
    parameter int PIXELS_PER_WORD = 16,
    parameter int IMG_ADDR_W      = 15,
    parameter int BIN_W           = 32
) (
    input  logic                               clock,
    input  logic                               rst,
    input  logic                               start,
    input  logic [IMG_ADDR_W:0]                num_words,
    input  logic                               bank_sel,
    output logic [IMG_ADDR_W-1:0]              img_addr,
    input  logic [PIXEL_W*PIXELS_PER_WORD-1:0] img_rdata,
    output logic [PIXEL_W:0]                   bin_raddr,
    input  logic [BIN_W-1:0]                   bin_rdata,
    output logic [PIXEL_W:0]                   bin_waddr,
    output logic [BIN_W-1:0]                   bin_wdata,
    output logic                               bin_we,
    output logic                               busy,
    output logic                               done
);

    localparam int PPW    = PIXELS_PER_WORD;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(PPW - 1);
    localparam logic [PIXEL_W-1:0] LAST_BIN  = PIXEL_W'(nbins(PIXEL_W) - 1);

    logic [2:0]              state;
    logic                    bank;
    logic [IMG_ADDR_W:0]     nwords;
    logic [IMG_ADDR_W:0]     word;
    logic [LANE_W-1:0]       lane;
    logic [1:0]              drain_cnt;
    logic [PIXEL_W-1:0]      p1, p2;
    logic                    v1, v2;
    logic                    wr1_we;
    logic [PIXEL_W:0]        wr1_addr;
    logic [BIN_W-1:0]        wr1_data;
    logic [BIN_W-1:0]        cnt;

    logic [PIXEL_W-1:0]      pixel;
    logic                    last_lane, last_word, abort;
    logic [LANE_W-1:0]       lane_n;
    logic [IMG_ADDR_W:0]     word_n;
    logic [IMG_ADDR_W-1:0]   img_addr_n;

    always_comb begin
        pixel      = img_rdata[int'(lane)*PIXEL_W +: PIXEL_W];
        last_lane  = (lane == LAST_LANE);
        last_word  = (word == nwords - 1'b1);
        lane_n     = last_lane ? '0 : lane + 1'b1;
        word_n     = last_lane ? word + 1'b1 : word;
        // Prefetch the next word while its predecessor's last lane is selected.
        img_addr_n = (lane_n == LAST_LANE) ? IMG_ADDR_W'(word_n + 1'b1) : IMG_ADDR_W'(word_n);
        abort      = busy && !start;
    end

    assign busy = (state == ST_CLEAR) || (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);

    hist_fwd_acc #(
        .ADDR_W (PIXEL_W + 1),
        .BIN_W  (BIN_W)
    ) u_fwd_acc (
        .addr     ({bank, p2}),
        .rdata    (bin_rdata),
        .wr0_we   (bin_we),
        .wr0_addr (bin_waddr),
        .wr0_data (bin_wdata),
        .wr1_we   (wr1_we),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .cnt      (cnt)
    );

    // NOTE: the bin memory itself is never reset; the CLEAR pass zeroes the selected bank.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= ST_IDLE;
            bank      <= 1'b0;
            nwords    <= '0;
            word      <= '0;
            lane      <= '0;
            drain_cnt <= '0;
            p1        <= '0;
            p2        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            img_addr  <= '0;
            bin_raddr <= '0;
            bin_waddr <= '0;
            bin_wdata <= '0;
            bin_we    <= 1'b0;
            wr1_we    <= 1'b0;
            wr1_addr  <= '0;
            wr1_data  <= '0;
        end else begin
            v1        <= 1'b0;
            v2        <= v1;
            p2        <= p1;
            bin_we    <= v2;
            bin_waddr <= {bank, p2};
            bin_wdata <= cnt;
            wr1_we    <= bin_we;
            wr1_addr  <= bin_waddr;
            wr1_data  <= bin_wdata;

            if (abort) begin
                state  <= ST_IDLE;
                v1     <= 1'b0;
                v2     <= 1'b0;
                bin_we <= 1'b0;
                wr1_we <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (start) begin
                        state     <= ST_CLEAR;
                        bank      <= bank_sel;
                        nwords    <= num_words;
                        img_addr  <= '0;
                        bin_we    <= 1'b1;
                        bin_waddr <= {bank_sel, {PIXEL_W{1'b0}}};
                        bin_wdata <= '0;
                    end
                    ST_CLEAR: if (bin_waddr[PIXEL_W-1:0] == LAST_BIN) begin
                        state    <= (nwords == '0) ? ST_DONE : ST_RUN;
                        word     <= '0;
                        lane     <= '0;
                        img_addr <= (PPW == 1) ? IMG_ADDR_W'(1) : '0;
                    end else begin
                        bin_we    <= 1'b1;
                        bin_waddr <= bin_waddr + 1'b1;
                        bin_wdata <= '0;
                    end
                    ST_RUN: begin
                        // bin_raddr is registered with p1 so the read data meets p2 in A.
                        v1        <= 1'b1;
                        p1        <= pixel;
                        bin_raddr <= {bank, pixel};
                        lane      <= lane_n;
                        word      <= word_n;
                        img_addr  <= img_addr_n;
                        if (last_lane && last_word) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                            state <= ST_DONE;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    ST_DONE: if (!start) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hist_accum_pipe.sv
// Scoreboard bench for hist_accum_pipe: expected bin writes are queued at issue
// time and a negedge monitor compares every write the DUT presents.
module tb_hist_accum_pipe;

    localparam int PW  = 4;
    localparam int PPW = 4;
    localparam int AW  = 4;
    localparam int BW  = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst;

    logic          start_a, bank_a;
    logic [AW:0]   nw_a;
    logic [AW-1:0] img_addr_a;
    logic [15:0]   img_rdata_a;
    logic [PW:0]   bin_raddr_a, bin_waddr_a;
    logic [BW-1:0] bin_rdata_a, bin_wdata_a;
    logic          bin_we_a, busy_a, done_a;

    logic          start_b, bank_b;
    logic [AW:0]   nw_b;
    logic [AW-1:0] img_addr_b;
    logic [15:0]   img_rdata_b;
    logic [PW:0]   bin_raddr_b, bin_waddr_b;
    logic [1:0]    bin_rdata_b, bin_wdata_b;
    logic          bin_we_b, busy_b, done_b;

    logic [15:0]   img_mem [0:15];
    logic [BW-1:0] mem_a [0:31];
    logic [1:0]    mem_b [0:31];

    hist_accum_pipe #(.PIXEL_W(PW), .PIXELS_PER_WORD(PPW), .IMG_ADDR_W(AW), .BIN_W(BW)) dut_a (
        .clock(clock), .rst(rst), .start(start_a), .num_words(nw_a), .bank_sel(bank_a),
        .img_addr(img_addr_a), .img_rdata(img_rdata_a), .bin_raddr(bin_raddr_a),
        .bin_rdata(bin_rdata_a), .bin_waddr(bin_waddr_a), .bin_wdata(bin_wdata_a),
        .bin_we(bin_we_a), .busy(busy_a), .done(done_a)
    );

    hist_accum_pipe #(.PIXEL_W(PW), .PIXELS_PER_WORD(PPW), .IMG_ADDR_W(AW), .BIN_W(2)) dut_b (
        .clock(clock), .rst(rst), .start(start_b), .num_words(nw_b), .bank_sel(bank_b),
        .img_addr(img_addr_b), .img_rdata(img_rdata_b), .bin_raddr(bin_raddr_b),
        .bin_rdata(bin_rdata_b), .bin_waddr(bin_waddr_b), .bin_wdata(bin_wdata_b),
        .bin_we(bin_we_b), .busy(busy_b), .done(done_b)
    );

    // Synchronous memories; bin memories are read-first on a same-address write.
    always @(posedge clock) begin
        img_rdata_a <= img_mem[img_addr_a];
        img_rdata_b <= img_mem[img_addr_b];
        bin_rdata_a <= mem_a[bin_raddr_a];
        bin_rdata_b <= mem_b[bin_raddr_b];
        if (bin_we_a) mem_a[bin_waddr_a] <= bin_wdata_a;
        if (bin_we_b) mem_b[bin_waddr_b] <= bin_wdata_b;
    end

    typedef struct packed {
        logic [PW:0]   addr;
        logic [BW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    bit  mon_en = 1'b0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  mcount [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && !rst && bin_we_a) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", 64'(bin_waddr_a), 64'hFFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_waddr", 64'(bin_waddr_a), 64'(mon_e.addr));
                check("sb_wdata", 64'(bin_wdata_a), 64'(mon_e.data));
            end
        end
    end

    // Histogram model: clear writes, then one write per pixel carrying its running count.
    task automatic expect_run(input logic bank, input int nw);
        wr_t e;
        int  p;
        for (int i = 0; i < 16; i++) begin
            mcount[i] = 0;
            e.addr = {bank, 4'(i)};
            e.data = '0;
            exp_q.push_back(e);
        end
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < PPW; k++) begin
                p = int'(img_mem[w][4*k +: 4]);
                mcount[p]++;
                e.addr = {bank, 4'(p)};
                e.data = BW'(mcount[p]);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_a(input string tag, input int nw, input logic bank);
        int exp_cyc;
        int cyc;
        int last_we;
        bit seen;
        expect_run(bank, nw);
        exp_cyc = 17 + ((nw > 0) ? nw * PPW + 3 : 0);
        nw_a    = 5'(nw);
        bank_a  = bank;
        start_a = 1'b1;
        cyc     = 0;
        last_we = 0;
        seen    = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (bin_we_a) last_we = cyc;
            if (done_a) seen = 1'b1;
        end
        check({tag, "_done_latency"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_last_write"}, 64'(last_we), 64'(exp_cyc - 1));
        check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy_a), 64'd0);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_bin"}, 64'(mem_a[{bank, 4'(i)}]), 64'(mcount[i]));
        end
        start_a = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check({tag, "_done_clear"}, 64'(done_a), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1;
        start_a = 1'b0; bank_a = 1'b0; nw_a = '0;
        start_b = 1'b0; bank_b = 1'b0; nw_b = '0;
        for (int i = 0; i < 16; i++) img_mem[i] = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_img_addr", 64'(img_addr_a), 64'd0);
        check("rst_bin_raddr", 64'(bin_raddr_a), 64'd0);
        check("rst_bin_waddr", 64'(bin_waddr_a), 64'd0);
        check("rst_bin_wdata", 64'(bin_wdata_a), 64'd0);
        check("rst_bin_we", 64'(bin_we_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        rst = 1'b0;
        @(negedge clock);
        mon_en = 1'b1;

        // Distinct pixels 0..7 across two words.
        img_mem[0] = 16'h3210; img_mem[1] = 16'h7654;
        run_a("t1", 2, 1'b0);
        check("t1_bin7", 64'(mem_a[7]), 64'd1);
        check("t1_bin8", 64'(mem_a[8]), 64'd0);

        // Every pixel identical: first-level forwarding each cycle.
        img_mem[0] = 16'h5555; img_mem[1] = 16'h5555; img_mem[2] = 16'h5555;
        run_a("t2", 3, 1'b0);
        check("t2_bin5", 64'(mem_a[5]), 64'd12);

        // Alternating pixels: second-level forwarding.
        for (int i = 0; i < 4; i++) img_mem[i] = 16'h9292;
        run_a("t3", 4, 1'b0);
        check("t3_bin2", 64'(mem_a[2]), 64'd8);
        check("t3_bin9", 64'(mem_a[9]), 64'd8);

        // Empty image on bank 1: clear pass only.
        run_a("t4", 0, 1'b1);

        // Abort two cycles into RUN, then restart.
        mon_en = 1'b0;
        exp_q.delete();
        img_mem[0] = 16'hFFFF; img_mem[1] = 16'hFFFF;
        nw_a = 5'd2; bank_a = 1'b0; start_a = 1'b1;
        repeat (18) @(posedge clock);
        @(negedge clock);
        check("t5_busy_before_abort", 64'(busy_a), 64'd1);
        start_a = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("t5_abort_idle", 64'(busy_a), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("t5_abort_no_we", 64'(bin_we_a), 64'd0);
            @(negedge clock);
        end
        mon_en = 1'b1;
        run_a("t5", 1, 1'b0);
        check("t5_bin15", 64'(mem_a[15]), 64'd4);

        // Two-bit bins, eight pixels of value 1.
        img_mem[0] = 16'h1111; img_mem[1] = 16'h1111;
        nw_b = 5'd2; bank_b = 1'b0; start_b = 1'b1;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (done_b) seen = 1'b1;
        end
        check("t6_done_latency", 64'(cyc), 64'd28);
`ifdef HIST_SAT_EN
        check("t6_bin1", 64'(mem_b[1]), 64'd3);
`else
        check("t6_bin1", 64'(mem_b[1]), 64'd0);
`endif
        check("t6_bin0", 64'(mem_b[0]), 64'd0);
        check("t6_bin2", 64'(mem_b[2]), 64'd0);
        start_b = 1'b0;
        repeat (2) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
